recompute_data_buffer: RTL
==========================

# recompute_data_buffer

Multi-port word store for the Recompute Unit (RU) BISR path. Every RU channel can capture a faulty PE's output word at a `(row, col)` location and read it back with a registered, handshaked port. Each entry has a valid bit, there is a live occupancy count, and entries can be consumed on read. The block sits between the systolic-array output taps and the NUM_RU recompute units.

## Interface
Parameters:
- `ROWS`, 4: array rows, ≥1.
- `COLS`, 4: array columns, ≥1.
- `NUM_RU`, 4: channel count, ≥1.
- `WORD_SIZE`, 16: data word width.
- Derived: `RW = max(1, $clog2(ROWS))`, `CW = max(1, $clog2(COLS))`, `OW = $clog2(ROWS*COLS+1)`.

Ports. Clock is one clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: clear all valid bits.
- `wr_en` in [NUM_RU]: per-channel write strobe.
- `wr_row` in [NUM_RU][RW], `wr_col` in [NUM_RU][CW]: binary write address.
- `wr_data` in [NUM_RU][WORD_SIZE]: write data.
- `rd_req` in [NUM_RU]: per-channel read request.
- `rd_pop` in [NUM_RU]: consume-on-read qualifier. It is only meaningful when `rd_req` is also high.
- `rd_row` in [NUM_RU][RW], `rd_col` in [NUM_RU][CW]: read address.
- `rd_valid` out [NUM_RU]: read response strobe.
- `rd_hit` out [NUM_RU]: the addressed entry was valid.
- `rd_data` out [NUM_RU][WORD_SIZE]: read data.
- `wr_conflict` out 1: same-cycle write collision pulse.
- `occupancy` out OW: number of valid entries.

## Operation
- **Storage.** ROWS×COLS words, each with a valid bit. The data array is not reset. Valid bits reset to 0.
- **Write.**
  - `wr_en[i]` sets entry `(wr_row[i], wr_col[i])` to `wr_data[i]` and sets its valid bit at the clock edge.
  - An out-of-range address (row ≥ ROWS or col ≥ COLS) is dropped without side effects.
- **Write collision.**
  - When two or more channels write the same entry in one cycle, the lowest channel index wins.
  - `wr_conflict` is 1 for the cycle after the collision.
- **Read.**
  - `rd_req[i]` samples the address.
  - Next cycle: `rd_valid[i]=1`, `rd_hit[i]` = the valid bit, and `rd_data[i]` = the entry content.
  - Both values are taken before any update in the request cycle.
  - On a miss or out-of-range address: `rd_hit=0`, `rd_data=0`.
- **Pop.**
  - `rd_req[i] & rd_pop[i]` on a valid entry clears its valid bit at the edge.
  - Several channels popping the same entry clear it once, and all of them see a hit.
- **Write vs pop on the same entry, same cycle.** The write wins: the entry stays valid with the new data.
- **Flush.**
  - All valid bits are cleared at the edge and `occupancy=0` the next cycle.
  - Writes in the flush cycle are dropped.
  - Reads in the flush cycle return pre-flush content. Pops in that cycle have no further effect.
- **Occupancy.**
  - Registered. Next value = current + (entries going 0→1) − (entries going 1→0), evaluated per entry.
  - It never exceeds ROWS×COLS.

## Timing
- **Reset values:** `rd_valid=0`, `rd_hit=0`, `rd_data=0`, `wr_conflict=0`, `occupancy=0`, all valid bits 0. Reset overrides flush, write and read.
- **Read latency:** 1 cycle, fully pipelined. One request per channel per cycle is accepted.
- **No backpressure.** `rd_valid` is a single-cycle pulse and the consumer must take it.
- **Write to read:** a write at cycle N is visible to a read requested at N+1. A read requested at cycle N returns the old data.
- **Occupancy** reflects the edge at the end of the cycle in which the triggering write, pop or flush occurred.

## Configuration
- Macro `RU_BUF_PARITY_EN`.
- **When defined:**
  - Each entry stores an even-parity bit computed on write.
  - An extra output `rd_perr` [NUM_RU] is asserted alongside `rd_valid` when a hit word fails its parity check.
  - `rd_data` is still returned unchanged.
  - A miss never flags.
- **When undefined:** no parity storage and no `rd_perr` port.

## Structure
- **Package `ru_buf_pkg`:**
  - Address-width helper function.
  - Typedef for the entry (data, plus the parity bit when enabled).
  - Typedef for the `(row, col)` address pair.
  - The out-of-range check function.
- **Sub-module `ru_buf_rd_port`,** instantiated NUM_RU times. It holds the address range check, the registered output mux, and the response (`rd_valid`/`rd_hit`/`rd_data`) and pop-request generation.
- **Write arbitration, valid array and occupancy** stay in the top module.

## Test plan
- **Write then read:** ch0 writes 0xBEEF to (2,3); ch1 reads (2,3) on the next cycle → one cycle later `rd_valid[1]=1`, `rd_hit=1`, `rd_data=0xBEEF`, `occupancy=1`.
- **Collision:** ch1 writes 0x1111 and ch2 writes 0x2222 to (0,0) in the same cycle → `wr_conflict` pulses once; a later read returns 0x1111; `occupancy=1`.
- **Pop versus write:** a valid entry (1,1) is popped by ch0 while ch3 writes 0x00AA to it in the same cycle → the ch0 response hits with the old data; the entry stays valid with 0x00AA; `occupancy` is unchanged.
- **Fill and flush:** write all 16 entries → `occupancy=16`. Assert `flush` with a simultaneous write → `occupancy=0`; every read misses with `rd_data=0`.
- **Reset mid-operation:** assert `rst` while reads are in flight → `rd_valid=0` the next cycle and all valid bits cleared. With `RU_BUF_PARITY_EN` defined, force a stored bit flip → `rd_perr=1` on the hit.

Source files
------------

// File: rtl/ru_buf_pkg.sv
// ----------------------------------------------------------------------------
// ru_buf_pkg
// Shared types and helpers for the recompute data buffer.
//   addr_w      : address width helper, never returns less than 1
//   ru_entry_t  : one stored word (plus its even-parity bit when
//                 RU_BUF_PARITY_EN is defined)
//   ru_addr_t   : (row, col) address pair, zero-extended to RU_ADDR_MAX bits
//   addr_oor    : out-of-range check of an address pair against the array size
//   even_par    : parity bit that makes the stored word + bit even
// Optional feature macro: RU_BUF_PARITY_EN
// The entry data width is fixed at RU_WORD_SIZE; the top-level WORD_SIZE
// parameter defaults to it and must be kept equal.
// ----------------------------------------------------------------------------
package ru_buf_pkg;

    localparam int RU_WORD_SIZE = 16;
    localparam int RU_ADDR_MAX  = 16;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
`ifdef RU_BUF_PARITY_EN
        logic                    parity;
`endif
        logic [RU_WORD_SIZE-1:0] data;
    } ru_entry_t;

    typedef struct packed {
        logic [RU_ADDR_MAX-1:0] row;
        logic [RU_ADDR_MAX-1:0] col;
    } ru_addr_t;

    function automatic logic addr_oor(input ru_addr_t a, input int rows, input int cols);
        return (int'(a.row) >= rows) || (int'(a.col) >= cols);
    endfunction

    function automatic logic even_par(input logic [RU_WORD_SIZE-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/recompute_data_buffer_rd_port.sv
// ----------------------------------------------------------------------------
// ru_buf_rd_port
// One registered read channel of the recompute data buffer.
//   clk, rst           : clock, synchronous active-high reset
//   rd_req, rd_pop     : read request and consume-on-read qualifier
//   rd_row, rd_col     : read address
//   valid_vec, mem     : current valid bits and stored entries (pre-update)
//   pop_req            : one-hot entry to clear this cycle (valid hit + pop)
//   rd_valid/hit/data  : response, one cycle after the request
//   rd_perr            : parity error on a hit (RU_BUF_PARITY_EN only)
// ----------------------------------------------------------------------------
module ru_buf_rd_port
    import ru_buf_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = RU_WORD_SIZE,
    parameter int RW        = 2,
    parameter int CW        = 2,
    parameter int ENTRIES   = ROWS * COLS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req,
    input  logic                         rd_pop,
    input  logic [RW-1:0]                rd_row,
    input  logic [CW-1:0]                rd_col,
    input  logic [ENTRIES-1:0]           valid_vec,
    input  ru_entry_t [ENTRIES-1:0]      mem,
    output logic [ENTRIES-1:0]           pop_req,
`ifdef RU_BUF_PARITY_EN
    output logic                         rd_perr,
`endif
    output logic                         rd_valid,
    output logic                         rd_hit,
    output logic [WORD_SIZE-1:0]         rd_data
);

    localparam int IW = addr_w(ENTRIES);

    ru_addr_t              addr;
    logic                  oor;
    logic [IW-1:0]         idx;
    logic                  hit_now;
    ru_entry_t             sel;

    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_hit_q,   rd_hit_d;
    logic [WORD_SIZE-1:0]  rd_data_q,  rd_data_d;

    assign addr.row = RU_ADDR_MAX'(rd_row);
    assign addr.col = RU_ADDR_MAX'(rd_col);
    assign oor      = addr_oor(addr, ROWS, COLS);

    // Out-of-range addresses are parked on entry 0 and masked from the hit.
    always_comb begin
        idx = '0;
        if (!oor) begin
            idx = IW'(int'(rd_row) * COLS + int'(rd_col));
        end
    end

    assign sel     = mem[idx];
    assign hit_now = rd_req && !oor && valid_vec[idx];
    assign pop_req = (hit_now && rd_pop) ? (ENTRIES'(1) << idx) : '0;

    always_comb begin
        rd_valid_d = rd_req;
        rd_hit_d   = hit_now;
        rd_data_d  = hit_now ? sel.data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef RU_BUF_PARITY_EN
    logic rd_perr_q, rd_perr_d;

    // A miss never flags; a hit flags when data + stored bit have odd weight.
    assign rd_perr_d = hit_now && (^{sel.parity, sel.data});

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_perr_q <= 1'b0;
        end else begin
            rd_perr_q <= rd_perr_d;
        end
    end

    assign rd_perr = rd_perr_q;
`endif

    assign rd_valid = rd_valid_q;
    assign rd_hit   = rd_hit_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/recompute_data_buffer.sv
// ----------------------------------------------------------------------------
// recompute_data_buffer
// ROWS x COLS word store shared by NUM_RU recompute channels.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : clear all valid bits (writes in that cycle dropped)
//   wr_en/row/col/data  : per-channel write port, lowest channel wins ties
//   rd_req/pop/row/col  : per-channel read request, optional consume
//   rd_valid/hit/data   : per-channel registered response (1-cycle latency)
//   rd_perr             : per-channel parity error (RU_BUF_PARITY_EN only)
//   wr_conflict         : pulse the cycle after a same-entry write collision
//   occupancy           : number of valid entries
// Optional feature macro: RU_BUF_PARITY_EN
// ----------------------------------------------------------------------------
module recompute_data_buffer
    import ru_buf_pkg::*;
#(
    parameter  int ROWS      = 4,
    parameter  int COLS      = 4,
    parameter  int NUM_RU    = 4,
    parameter  int WORD_SIZE = RU_WORD_SIZE,
    localparam int RW        = addr_w(ROWS),
    localparam int CW        = addr_w(COLS),
    localparam int OW        = $clog2(ROWS * COLS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [NUM_RU-1:0]                 wr_en,
    input  logic [NUM_RU-1:0][RW-1:0]         wr_row,
    input  logic [NUM_RU-1:0][CW-1:0]         wr_col,
    input  logic [NUM_RU-1:0][WORD_SIZE-1:0]  wr_data,
    input  logic [NUM_RU-1:0]                 rd_req,
    input  logic [NUM_RU-1:0]                 rd_pop,
    input  logic [NUM_RU-1:0][RW-1:0]         rd_row,
    input  logic [NUM_RU-1:0][CW-1:0]         rd_col,
    output logic [NUM_RU-1:0]                 rd_valid,
    output logic [NUM_RU-1:0]                 rd_hit,
    output logic [NUM_RU-1:0][WORD_SIZE-1:0]  rd_data,
`ifdef RU_BUF_PARITY_EN
    output logic [NUM_RU-1:0]                 rd_perr,
`endif
    output logic                              wr_conflict,
    output logic [OW-1:0]                     occupancy
);

    localparam int ENTRIES = ROWS * COLS;
    localparam int IW      = addr_w(ENTRIES);

    logic [ENTRIES-1:0]              valid_q, valid_d;
    ru_entry_t [ENTRIES-1:0]         mem_q;
    logic [OW-1:0]                   occ_q, occ_d;
    logic                            conflict_q, conflict_d;

    logic [NUM_RU-1:0]               wr_ok;
    logic [NUM_RU-1:0][IW-1:0]       wr_idx;
    logic [ENTRIES-1:0]              wr_hit;
    ru_entry_t [ENTRIES-1:0]         wr_ent;
    logic [NUM_RU-1:0][ENTRIES-1:0]  pop_req;
    logic [ENTRIES-1:0]              pop_any;

    always_comb begin
        for (int i = 0; i < NUM_RU; i++) begin
            ru_addr_t a;
            a.row     = RU_ADDR_MAX'(wr_row[i]);
            a.col     = RU_ADDR_MAX'(wr_col[i]);
            wr_ok[i]  = wr_en[i] && !flush && !addr_oor(a, ROWS, COLS);
            wr_idx[i] = wr_ok[i] ? IW'(int'(wr_row[i]) * COLS + int'(wr_col[i])) : '0;
        end
    end

    // Per entry, scan channels low to high: the first writer wins and any
    // later writer to the same entry raises the collision flag.
    always_comb begin
        conflict_d = 1'b0;
        for (int e = 0; e < ENTRIES; e++) begin
            wr_hit[e] = 1'b0;
            wr_ent[e] = '0;
            for (int i = 0; i < NUM_RU; i++) begin
                if (wr_ok[i] && (wr_idx[i] == IW'(e))) begin
                    if (wr_hit[e]) begin
                        conflict_d = 1'b1;
                    end else begin
                        wr_hit[e]      = 1'b1;
                        wr_ent[e].data = wr_data[i];
`ifdef RU_BUF_PARITY_EN
                        wr_ent[e].parity = even_par(wr_data[i]);
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        pop_any = '0;
        for (int i = 0; i < NUM_RU; i++) begin
            pop_any = pop_any | pop_req[i];
        end
    end

    // Priority per entry: flush, then write, then pop.
    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        for (int e = 0; e < ENTRIES; e++) begin
            if (flush) begin
                valid_d[e] = 1'b0;
            end else if (wr_hit[e]) begin
                valid_d[e] = 1'b1;
            end else if (pop_any[e]) begin
                valid_d[e] = 1'b0;
            end
            if (valid_d[e] && !valid_q[e]) begin
                occ_d = occ_d + OW'(1);
            end
            if (!valid_d[e] && valid_q[e]) begin
                occ_d = occ_d - OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            occ_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            occ_q      <= occ_d;
            conflict_q <= conflict_d;
        end
    end

    // Data array carries no reset; valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENTRIES; e++) begin
            if (!rst && wr_hit[e]) begin
                mem_q[e] <= wr_ent[e];
            end
        end
    end

    for (genvar i = 0; i < NUM_RU; i++) begin : g_rd
        ru_buf_rd_port #(
            .ROWS      (ROWS),
            .COLS      (COLS),
            .WORD_SIZE (WORD_SIZE),
            .RW        (RW),
            .CW        (CW),
            .ENTRIES   (ENTRIES)
        ) u_rd_port (
            .clk       (clk),
            .rst       (rst),
            .rd_req    (rd_req[i]),
            .rd_pop    (rd_pop[i]),
            .rd_row    (rd_row[i]),
            .rd_col    (rd_col[i]),
            .valid_vec (valid_q),
            .mem       (mem_q),
            .pop_req   (pop_req[i]),
`ifdef RU_BUF_PARITY_EN
            .rd_perr   (rd_perr[i]),
`endif
            .rd_valid  (rd_valid[i]),
            .rd_hit    (rd_hit[i]),
            .rd_data   (rd_data[i])
        );
    end

    assign wr_conflict = conflict_q;
    assign occupancy   = occ_q;

endmodule
